// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the CDB arbiter.
// The arbiter uses the slave modport; the producers and the bench drive through master.
interface cdb_arbiter_if #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 32
);
  logic                    valid_from_alu;
  logic [ROB_ID_WIDTH-1:0] rob_id_from_alu;
  logic [DATA_WIDTH-1:0]   result_from_alu;
  logic                    valid_from_lsb;
  logic [ROB_ID_WIDTH-1:0] rob_id_from_lsb;
  logic [DATA_WIDTH-1:0]   result_from_lsb;
  logic                    full_to_alu;
  logic                    full_to_lsb;
  logic                    cdb_valid;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id;
  logic [DATA_WIDTH-1:0]   cdb_result;
  logic                    cdb_src;

  modport master (
    output valid_from_alu, rob_id_from_alu, result_from_alu,
    output valid_from_lsb, rob_id_from_lsb, result_from_lsb,
    input  full_to_alu, full_to_lsb,
    input  cdb_valid, cdb_rob_id, cdb_result, cdb_src
  );

  modport slave (
    input  valid_from_alu, rob_id_from_alu, result_from_alu,
    input  valid_from_lsb, rob_id_from_lsb, result_from_lsb,
    output full_to_alu, full_to_lsb,
    output cdb_valid, cdb_rob_id, cdb_result, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter (ALU vs LSB) with a per-source FIFO and empty-FIFO bypass;
// one-cycle registered broadcast, full_to_x backpressure from pre-edge count, rdy=0 freezes all.
module cdb_arbiter #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          flush_from_rob,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [DATA_WIDTH-1:0]   result;
  } entry_t;

  // Index 0 is the ALU source, index 1 the LSB source.
  entry_t                  mem_q    [2][FIFO_DEPTH];
  entry_t                  mem_d    [2][FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr_q [2];
  logic [PW-1:0]           rd_ptr_d [2];
  logic [PW-1:0]           wr_ptr_q [2];
  logic [PW-1:0]           wr_ptr_d [2];
  logic [CW-1:0]           count_q  [2];
  logic [CW-1:0]           count_d  [2];
  logic                    last_grant_q, last_grant_d;
  logic                    cdb_valid_q, cdb_valid_d;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_WIDTH-1:0]   cdb_result_q, cdb_result_d;
  logic                    cdb_src_q, cdb_src_d;

  entry_t     in_ent   [2];
  entry_t     cand_ent [2];
  entry_t     gnt_ent;
  logic [1:0] in_vld, empty, full, cand, gnt, push, pop;

  always_comb begin
    in_vld    = {bus.valid_from_lsb, bus.valid_from_alu};
    in_ent[0] = '{rob_id: bus.rob_id_from_alu, result: bus.result_from_alu};
    in_ent[1] = '{rob_id: bus.rob_id_from_lsb, result: bus.result_from_lsb};
    for (int s = 0; s < 2; s++) begin
      empty[s]    = (count_q[s] == '0);
      full[s]     = (count_q[s] == CW'(FIFO_DEPTH));
      cand[s]     = !empty[s] || in_vld[s];
      cand_ent[s] = empty[s] ? in_ent[s] : mem_q[s][rd_ptr_q[s]];
    end
    // On a tie the source that did not win last time takes the bus.
    gnt[1] = cand[1] && (!cand[0] || (last_grant_q == SRC_ALU));
    gnt[0] = cand[0] && !gnt[1];
    gnt_ent = gnt[1] ? cand_ent[1] : cand_ent[0];
    for (int s = 0; s < 2; s++) begin
      pop[s]  = gnt[s] && !empty[s];
      // A result taken by bypass never enters the FIFO; one arriving while full is dropped.
      push[s] = in_vld[s] && !full[s] && !(gnt[s] && empty[s]);
    end
  end

  assign bus.full_to_alu = full[0];
  assign bus.full_to_lsb = full[1];
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob_id  = cdb_rob_id_q;
  assign bus.cdb_result  = cdb_result_q;
  assign bus.cdb_src     = cdb_src_q;

  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_result_d = cdb_result_q;
    cdb_src_d    = cdb_src_q;
    if (flush_from_rob) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr_d[s] = '0;
        wr_ptr_d[s] = '0;
        count_d[s]  = '0;
      end
      cdb_valid_d  = 1'b0;
      cdb_rob_id_d = '0;
      cdb_result_d = '0;
      cdb_src_d    = SRC_ALU;
    end else if (rdy) begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          mem_d[s][wr_ptr_q[s]] = in_ent[s];
          wr_ptr_d[s]           = wr_ptr_q[s] + PW'(1);
        end
        if (pop[s]) begin
          rd_ptr_d[s] = rd_ptr_q[s] + PW'(1);
        end
        count_d[s] = count_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
      cdb_valid_d = |cand;
      if (|gnt) begin
        last_grant_d = gnt[1];
        cdb_src_d    = gnt[1];
        cdb_rob_id_d = gnt_ent.rob_id;
        cdb_result_d = gnt_ent.result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      last_grant_q <= SRC_LSB;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_result_q <= '0;
      cdb_src_q    <= SRC_ALU;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_result_q <= cdb_result_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  // Storage contents are only meaningful below count, so they carry no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed per-cycle vectors for cdb_arbiter: each record drives one cycle and
// gives the expected full flags and CDB registers after that cycle's edge.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic flush_from_rob = 1'b0;

  cdb_arbiter_if #(.ROB_ID_WIDTH(4), .DATA_WIDTH(32)) bus ();

  cdb_arbiter #(.ROB_ID_WIDTH(4), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush_from_rob (flush_from_rob),
    .bus            (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, flush;
    logic        va;
    logic [3:0]  ida;
    logic [31:0] da;
    logic        vl;
    logic [3:0]  idl;
    logic [31:0] dl;
    logic        efa, efl, ecv;
    logic [3:0]  eid;
    logic [31:0] edat;
    logic        esrc;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(input logic r, input logic y, input logic f,
                              input logic va, input logic [3:0] ida, input logic [31:0] da,
                              input logic vl, input logic [3:0] idl, input logic [31:0] dl,
                              input logic efa, input logic efl, input logic ecv,
                              input logic [3:0] eid, input logic [31:0] edat, input logic esrc);
    vec_t v;
    v.rst = r; v.rdy = y; v.flush = f;
    v.va = va; v.ida = ida; v.da = da;
    v.vl = vl; v.idl = idl; v.dl = dl;
    v.efa = efa; v.efl = efl; v.ecv = ecv;
    v.eid = eid; v.edat = edat; v.esrc = esrc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @vec %0d: got %h, expected %h", nm, idx, act, exp);
  endtask

  task automatic step(input vec_t v, input int idx, input bit proto);
    rst = v.rst; rdy = v.rdy; flush_from_rob = v.flush;
    bus.valid_from_alu = v.va; bus.rob_id_from_alu = v.ida; bus.result_from_alu = v.da;
    bus.valid_from_lsb = v.vl; bus.rob_id_from_lsb = v.idl; bus.result_from_lsb = v.dl;
    // A producer must never present while its FIFO reports full.
    if (proto && !v.rst && v.va) chk("proto_alu_full", idx, 32'(bus.full_to_alu), 32'd0);
    if (proto && !v.rst && v.vl) chk("proto_lsb_full", idx, 32'(bus.full_to_lsb), 32'd0);
    @(posedge clk);
    #1;
    chk("full_to_alu", idx, 32'(bus.full_to_alu), 32'(v.efa));
    chk("full_to_lsb", idx, 32'(bus.full_to_lsb), 32'(v.efl));
    chk("cdb_valid",   idx, 32'(bus.cdb_valid),   32'(v.ecv));
    chk("cdb_rob_id",  idx, 32'(bus.cdb_rob_id),  32'(v.eid));
    chk("cdb_result",  idx, bus.cdb_result,       v.edat);
    chk("cdb_src",     idx, 32'(bus.cdb_src),     32'(v.esrc));
  endtask

  initial begin
    bus.valid_from_alu = 1'b0; bus.rob_id_from_alu = '0; bus.result_from_alu = '0;
    bus.valid_from_lsb = 1'b0; bus.rob_id_from_lsb = '0; bus.result_from_lsb = '0;

    // Reset, then a lone ALU result.
    tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,      0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,      0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 1,3,'hAA,   0,0,0,      0,0,1, 3,'hAA,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,0, 3,'hAA,0));
    // First tie after reset goes to the ALU.
    tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,      0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 1,1,'h11,   1,2,'h22,   0,0,1, 1,'h11,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,1, 2,'h22,1));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,0, 2,'h22,1));
    // Saturation: sources hold off while their full flag is high.
    tbl.push_back(mk(0,1,0, 1,1,'hA1,   1,9,'hB9,   0,0,1, 1,'hA1,0));
    tbl.push_back(mk(0,1,0, 1,2,'hA2,   1,10,'hBA,  0,0,1, 9,'hB9,1));
    tbl.push_back(mk(0,1,0, 1,3,'hA3,   1,11,'hBB,  0,1,1, 2,'hA2,0));
    tbl.push_back(mk(0,1,0, 1,4,'hA4,   0,0,0,      1,0,1, 10,'hBA,1));
    tbl.push_back(mk(0,1,0, 0,0,0,      1,12,'hBC,  0,1,1, 3,'hA3,0));
    tbl.push_back(mk(0,1,0, 1,5,'hA5,   0,0,0,      1,0,1, 11,'hBB,1));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,1, 4,'hA4,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,1, 12,'hBC,1));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,1, 5,'hA5,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,0, 5,'hA5,0));
    // Fill the LSB FIFO, then flush; held tags 15 and 1 must never appear.
    tbl.push_back(mk(0,1,0, 1,6,'hA6,   1,13,'hBD,  0,0,1, 13,'hBD,1));
    tbl.push_back(mk(0,1,0, 1,7,'hA7,   1,14,'hBE,  0,0,1, 6,'hA6,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      1,15,'hBF,  0,0,1, 14,'hBE,1));
    tbl.push_back(mk(0,1,0, 0,0,0,      1,1,'hC1,   0,1,1, 7,'hA7,0));
    tbl.push_back(mk(0,1,1, 1,2,'hC2,   0,0,0,      0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,0, 0,0,0));
    // Flush keeps last_grant (ALU), so this tie goes to the LSB.
    tbl.push_back(mk(0,1,0, 1,3,'h33,   1,4,'h44,   0,0,1, 4,'h44,1));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,1, 3,'h33,0));
    // One entry per FIFO, then rdy low for three cycles.
    tbl.push_back(mk(0,1,0, 1,5,'h55,   1,6,'h66,   0,0,1, 6,'h66,1));
    tbl.push_back(mk(0,1,0, 1,7,'h77,   1,8,'h88,   0,0,1, 5,'h55,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0, 1,9,'h99, 0,0,0,      0,0,1, 5,'h55,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,1, 8,'h88,1));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,1, 7,'h77,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,0, 7,'h77,0));
    // Reset mid-burst with valid inputs present.
    tbl.push_back(mk(0,1,0, 1,1,'h1,    1,2,'h2,    0,0,1, 2,'h2,1));
    tbl.push_back(mk(0,1,0, 1,3,'h3,    1,4,'h4,    0,0,1, 1,'h1,0));
    tbl.push_back(mk(1,1,0, 1,5,'h5,    1,6,'h6,    0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 1,9,'h9,    1,10,'hA,   0,0,1, 9,'h9,0));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,1, 10,'hA,1));
    tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,      0,0,0, 10,'hA,1));

    foreach (tbl[i]) step(tbl[i], i, 1'b1);

    // Illegal push while full is dropped: tag 7 must never be broadcast.
    step(mk(0,1,0, 1,1,'h1, 1,2,'h2, 0,0,1, 1,'h1,0), 100, 1'b1);
    step(mk(0,1,0, 1,3,'h3, 1,4,'h4, 0,0,1, 2,'h2,1), 101, 1'b1);
    step(mk(0,1,0, 1,5,'h5, 1,6,'h6, 0,1,1, 3,'h3,0), 102, 1'b1);
    step(mk(0,1,0, 0,0,0,   1,7,'h7, 0,0,1, 4,'h4,1), 103, 1'b0);
    step(mk(0,1,0, 0,0,0,   0,0,0,   0,0,1, 5,'h5,0), 104, 1'b1);
    step(mk(0,1,0, 0,0,0,   0,0,0,   0,0,1, 6,'h6,1), 105, 1'b1);
    step(mk(0,1,0, 0,0,0,   0,0,0,   0,0,0, 6,'h6,1), 106, 1'b1);
    // Flush takes priority over rdy low.
    step(mk(0,1,0, 1,8,'h8, 1,9,'h9, 0,0,1, 8,'h8,0), 107, 1'b1);
    step(mk(0,0,1, 0,0,0,   0,0,0,   0,0,0, 0,0,0),   108, 1'b1);
    step(mk(0,1,0, 0,0,0,   0,0,0,   0,0,0, 0,0,0),   109, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: the ALU reservation station and the load/store buffer.
- Each source gets a small FIFO so no result is lost when both finish in the same cycle.
- The granted result is broadcast, registered, to the ROB, RS, LSB and the dispatch forwarding logic (which compares its Q tags against the CDB tag).
- Round-robin fairness; whole contents discarded on a commit-time jump flush.

Parameters:
- ROB_ID_WIDTH, 4, width of ROB tag (tag 0 = ZERO_ROB, never broadcast as a real result).
- DATA_WIDTH, 32, result width.
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- rdy  input  1  global ready; low = freeze all state.
- flush_from_rob  input  1  commit jump flag; discard all pending results.
- valid_from_alu  input  1  ALU result valid this cycle.
- rob_id_from_alu  input  ROB_ID_WIDTH  ALU result tag.
- result_from_alu  input  DATA_WIDTH  ALU result value.
- valid_from_lsb  input  1  LSB result valid this cycle.
- rob_id_from_lsb  input  ROB_ID_WIDTH  LSB result tag.
- result_from_lsb  input  DATA_WIDTH  LSB result value.
- full_to_alu  output  1  ALU FIFO full; ALU must not present a result.
- full_to_lsb  output  1  LSB FIFO full; LSB must not present a result.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_rob_id  output  ROB_ID_WIDTH  broadcast tag (registered).
- cdb_result  output  DATA_WIDTH  broadcast value (registered).
- cdb_src  output  1  0 = ALU, 1 = LSB (registered; debug/verification).

Behaviour:
- Priority at each posedge: rst > flush_from_rob > !rdy (hold) > normal operation.
- Reset: both FIFOs empty (counts 0, pointers 0), cdb_valid=0, cdb_rob_id=0, cdb_result=0, cdb_src=0. last_grant=LSB, so ALU wins the first tie.
- Flush: same as reset, except last_grant is kept. Inputs presented in the flush cycle are dropped.
- rdy low: FIFOs, last_grant and all cdb_* outputs hold. Inputs are ignored; sources are frozen by the same rdy.
- full_to_x: combinational, equals (count_x == FIFO_DEPTH). It is based on the pre-edge count and does not look ahead to a pop in the same cycle.
- Candidate per source:
  - FIFO non-empty: the FIFO head.
  - FIFO empty and valid_from_x: the incoming result (bypass).
  - Otherwise none.
- Grant:
  - Only one candidate: that one.
  - Both: the source not equal to last_grant; last_grant updates to the granted source.
  - None: last_grant unchanged.
- Output register: cdb_valid <= any candidate. On a grant, cdb_rob_id/cdb_result/cdb_src <= the granted candidate. With no grant, cdb_valid <= 0 and tag/data hold their previous value.
- Latency: an input presented while its FIFO is empty and uncontested reaches the CDB registers at the same edge, i.e. it is visible one cycle after being presented.
- FIFO update per source, same edge:
  - Pop if the source was granted and its FIFO was non-empty.
  - Push the incoming result if valid_from_x and it was not consumed by bypass.
  - Push and pop may both occur; the count is unchanged in that case.
  - Pointers wrap modulo FIFO_DEPTH.
- Illegal input: valid_from_x while full_to_x is high is dropped, and the FIFO is unchanged. The bench flags this as a protocol error.
- Ordering: results from one source leave in arrival order. No ordering is guaranteed across sources.
- Throughput: at most one broadcast per cycle. With both sources saturated, the bus alternates ALU/LSB every cycle.

Test Plan:
- Reset, then ALU alone presents tag 3 / 0x0000_00AA for one cycle -> next cycle cdb_valid=1, tag 3, data 0xAA, cdb_src=0; following cycle cdb_valid=0; full flags stay 0.
- Same cycle: ALU tag 1 / 0x11 and LSB tag 2 / 0x22 -> cycle+1 broadcasts tag 1 (ALU wins the first tie); cycle+2 broadcasts tag 2; LSB count returns to 0.
- Both sources present every cycle for 6 cycles, each tag incrementing -> CDB alternates ALU,LSB,ALU,LSB…. Each source's tags come out in order. full_to_x rises once the FIFO holds 2, and the source stops presenting while it is high.
- FIFO_DEPTH=2: fill the LSB FIFO while the ALU keeps winning ties, then assert flush_from_rob -> next cycle cdb_valid=0, both counts 0, full flags 0. Results held before the flush never appear.
- rdy low for 3 cycles with both FIFOs holding one entry -> cdb outputs frozen and nothing lost. After rdy returns, the two entries are broadcast in round-robin order.
- rst asserted mid-burst, together with valid inputs -> next cycle all outputs are at reset values and no stale tag is ever broadcast.
